// File: rtl/core_mul_unit.sv
// Iterative shift-add multiplier for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL; retires STEP_BITS multiplier bits per cycle.
// Result and valid appear 32/STEP_BITS+1 cycles after start is accepted; ready is low while busy and extra starts are dropped.

package core_mul_pkg;
   typedef struct packed {
      logic       add;
      logic       long_mul;
      logic       signed_mul;
      logic [3:0] r_add_lo;
      logic [3:0] r_add_hi;
   } mul_decode;
endpackage

module core_mul_unit
   import core_mul_pkg::*;
#(
   parameter int STEP_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  mul_decode   decode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] acc_lo,
   input  logic [31:0] acc_hi,
   output logic        ready,
   output logic        valid,
   output logic [31:0] q_lo,
   output logic [31:0] q_hi,
   output logic        n,
   output logic        z
);

   localparam int         N_STEPS = 32 / STEP_BITS;
   localparam logic [4:0] LAST    = 5'(N_STEPS - 1);

   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [63:0] part_q, part_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic        long_q, long_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic [31:0] q_lo_q, q_lo_d;
   logic [31:0] q_hi_q, q_hi_d;
   logic        n_q, n_d;
   logic        z_q, z_d;

   logic        signed_long;
   logic [31:0] a_mag, b_mag;
   logic [63:0] step_sum;
   logic [63:0] p_fix;
   logic        unused_decode;

   assign unused_decode = ^{decode.r_add_lo, decode.r_add_hi};

   // Signed long multiplies run on magnitudes; the sign is reapplied in FIX.
   assign signed_long = decode.long_mul & decode.signed_mul;
   assign a_mag       = (signed_long && a[31]) ? (32'd0 - a) : a;
   assign b_mag       = (signed_long && b[31]) ? (32'd0 - b) : b;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      part_d   = part_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      long_d   = long_q;
      valid_d  = 1'b0;
      q_lo_d   = q_lo_q;
      q_hi_d   = q_hi_q;
      n_d      = n_q;
      z_d      = z_q;

      step_sum = '0;
      for (int i = 0; i < STEP_BITS; i++) begin
         if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
      end

      // A short accumulate only affects the low word, so a zero-extended acc_lo is exact there.
      p_fix = (neg_q ? (64'd0 - part_q) : part_q) + acc_q;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               state_d  = MUL;
               cnt_d    = '0;
               mcand_d  = {32'd0, a_mag};
               mplier_d = b_mag;
               part_d   = '0;
               neg_d    = signed_long & (a[31] ^ b[31]);
               long_d   = decode.long_mul;
               acc_d    = decode.add ? {(decode.long_mul ? acc_hi : 32'd0), acc_lo} : 64'd0;
            end
         end
         MUL: begin
            part_d   = part_q + step_sum;
            mcand_d  = mcand_q << STEP_BITS;
            mplier_d = mplier_q >> STEP_BITS;
            cnt_d    = cnt_q + 5'd1;
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               valid_d = 1'b1;
               q_lo_d  = p_fix[31:0];
               q_hi_d  = long_q ? p_fix[63:32] : 32'd0;
               n_d     = long_q ? p_fix[63] : p_fix[31];
               z_d     = long_q ? (p_fix == 64'd0) : (p_fix[31:0] == 32'd0);
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         part_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         long_q   <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         q_lo_q   <= '0;
         q_hi_q   <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         part_q   <= part_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         long_q   <= long_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         q_lo_q   <= q_lo_d;
         q_hi_q   <= q_hi_d;
         n_q      <= n_d;
         z_q      <= z_d;
      end
   end

   assign ready = ready_q;
   assign valid = valid_q;
   assign q_lo  = q_lo_q;
   assign q_hi  = q_hi_q;
   assign n     = n_q;
   assign z     = z_q;

endmodule

// File: tb/tb_core_mul_unit.sv
// Bench for core_mul_unit: three instances (STEP_BITS 1, 4, 8) driven one at a time.
// Directed vector table, handshake/flush/reset sequences, then random ops against a 64-bit arithmetic model.

module tb_core_mul_unit;
   import core_mul_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  start, flush;
   mul_decode   dec;
   logic [31:0] a, b, acc_lo, acc_hi;
   logic [2:0]  ready, valid, n, z;
   logic [31:0] q_lo [3];
   logic [31:0] q_hi [3];

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         core_mul_unit #(.STEP_BITS(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start[g]),
            .flush  (flush[g]),
            .decode (dec),
            .a      (a),
            .b      (b),
            .acc_lo (acc_lo),
            .acc_hi (acc_hi),
            .ready  (ready[g]),
            .valid  (valid[g]),
            .q_lo   (q_lo[g]),
            .q_hi   (q_hi[g]),
            .n      (n[g]),
            .z      (z[g])
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        add, lng, sgn;
      logic [31:0] a, b, alo, ahi;
      logic [65:0] exp; // {n, z, q_hi, q_lo}
   } vec_t;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int n_steps(input int k);
      return (k == 0) ? 32 : ((k == 1) ? 8 : 4);
   endfunction

   // Plain-arithmetic reference: full product, optional accumulate, truncation for short ops.
   function automatic logic [65:0] ref_model(input logic add, lng, sgn,
                                             input logic [31:0] ra, rb, alo, ahi);
      longint      sp;
      logic [63:0] r;
      logic        rn, rz;
      if (lng && sgn) begin
         sp = longint'($signed(ra)) * longint'($signed(rb));
         r  = sp;
      end else begin
         r = {32'd0, ra} * {32'd0, rb};
      end
      if (add) r = r + (lng ? {ahi, alo} : {32'd0, alo});
      if (!lng) r = {32'd0, r[31:0]};
      rn = lng ? r[63] : r[31];
      rz = lng ? (r == 64'd0) : (r[31:0] == 32'd0);
      return {rn, rz, r};
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   function automatic vec_t mkv(input logic add, lng, sgn, input logic [31:0] va, vb, alo, ahi,
                                input logic [65:0] exp);
      vec_t v;
      v.add = add; v.lng = lng; v.sgn = sgn;
      v.a = va; v.b = vb; v.alo = alo; v.ahi = ahi; v.exp = exp;
      return v;
   endfunction

   // Called 1 time unit after a rising edge. lat counts edges after the start-sampling edge.
   task automatic run_op(input int k, input logic add, lng, sgn,
                         input logic [31:0] ia, ib, alo, ahi, input int ign_at,
                         output logic [65:0] got, output int lat, output int low_cnt);
      dec.add        = add;
      dec.long_mul   = lng;
      dec.signed_mul = sgn;
      dec.r_add_lo   = 4'($urandom_range(0, 15));
      dec.r_add_hi   = 4'($urandom_range(0, 15));
      a = ia; b = ib; acc_lo = alo; acc_hi = ahi;
      start[k] = 1'b1;
      lat = -1; low_cnt = 0; got = '0;
      @(posedge clk); #1;
      start[k] = 1'b0;
      a = $urandom; b = $urandom; acc_lo = $urandom; acc_hi = $urandom;
      dec = mul_decode'($urandom);
      chk($sformatf("valid_one_shot k%0d", k), 66'(valid[k]), 66'd0);
      if (!ready[k]) low_cnt++;
      for (int c = 1; c <= 80; c++) begin
         if (c == ign_at) begin
            start[k] = 1'b1;
            a = 32'd9;
         end else begin
            start[k] = 1'b0;
         end
         @(posedge clk); #1;
         if (valid[k]) begin
            lat = c;
            got = {n[k], z[k], q_hi[k], q_lo[k]};
            break;
         end
         if (!ready[k]) low_cnt++;
      end
      start[k] = 1'b0;
      chk($sformatf("ready_with_valid k%0d", k), 66'(ready[k]), 66'd1);
   endtask

   task automatic watch_no_valid(input int k, input int cycles, input string name);
      int seen = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (valid[k]) seen++;
      end
      chk(name, 66'(seen), 66'd0);
   endtask

   vec_t        tbl [10];
   logic [65:0] got, exp;
   int          lat, low_cnt, nops;
   logic        r_add, r_lng, r_sgn;
   logic [31:0] ra, rb, ralo, rahi;

   initial begin
      tbl[0] = mkv(0, 0, 0, 32'd7, 32'd6, 32'd0, 32'd0, {2'b00, 64'h0000_0000_0000_002A});
      tbl[1] = mkv(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, {2'b10, 64'hFFFF_FFFE_0000_0001});
      tbl[2] = mkv(0, 1, 1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, {2'b10, 64'hFFFF_FFFF_FFFF_FFFA});
      tbl[3] = mkv(0, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, {2'b00, 64'h4000_0000_0000_0000});
      tbl[4] = mkv(1, 1, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, {2'b01, 64'h0});
      tbl[5] = mkv(1, 0, 0, 32'h8000_0000, 32'd2, 32'd5, 32'hDEAD_BEEF, {2'b00, 64'h0000_0000_0000_0005});
      tbl[6] = mkv(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {2'b10, 64'hFFFF_FFFE_0000_0000});
      tbl[7] = mkv(0, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h1234_5678, {2'b10, 64'h0000_0000_FFFF_FFFE});
      tbl[8] = mkv(0, 0, 0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, {2'b01, 64'h0});
      tbl[9] = mkv(0, 1, 1, 32'h8000_0000, 32'd1, 32'd0, 32'd0, {2'b10, 64'hFFFF_FFFF_8000_0000});

      rst_n = 1'b0; start = '0; flush = '0; dec = '0;
      a = '0; b = '0; acc_lo = '0; acc_hi = '0;
      #12;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_state k%0d", k),
             {30'd0, ready[k], valid[k], n[k], z[k], q_hi[k], q_lo[k]}, {30'd0, 4'b1000, 64'd0});
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) begin
            run_op(k, tbl[i].add, tbl[i].lng, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].alo, tbl[i].ahi,
                   -1, got, lat, low_cnt);
            chk($sformatf("tbl[%0d] k%0d", i, k), got, tbl[i].exp);
            chk($sformatf("tbl_latency[%0d] k%0d", i, k), 66'(lat), 66'(n_steps(k) + 1));
            chk($sformatf("tbl_busy[%0d] k%0d", i, k), 66'(low_cnt), 66'(n_steps(k) + 1));
         end
      end

      // Start while busy must be dropped.
      run_op(0, 0, 0, 0, 32'd7, 32'd6, 32'd0, 32'd0, 5, got, lat, low_cnt);
      chk("ignored_start_result", got, {2'b00, 64'd42});
      chk("ignored_start_latency", 66'(lat), 66'd33);
      watch_no_valid(0, 40, "ignored_start_not_queued");

      // Flush during MUL: no result, ready next cycle, outputs hold 42.
      dec = '0; a = 32'd3; b = 32'd5; start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush[0] = 1'b1;
      @(posedge clk); #1;
      flush[0] = 1'b0;
      chk("flush_mul_ready", 66'(ready[0]), 66'd1);
      chk("flush_mul_hold_q_lo", 66'(q_lo[0]), 66'd42);
      watch_no_valid(0, 40, "flush_mul_no_valid");

      // Flush during FIX on the 8-bit instance beats completion.
      dec = '0; a = 32'd3; b = 32'd5; start[2] = 1'b1;
      @(posedge clk); #1;
      start[2] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("fix_state_busy", 66'(ready[2]), 66'd0);
      flush[2] = 1'b1;
      @(posedge clk); #1;
      flush[2] = 1'b0;
      chk("flush_fix_no_valid", 66'(valid[2]), 66'd0);
      chk("flush_fix_ready", 66'(ready[2]), 66'd1);
      chk("flush_fix_hold_q", {2'b00, q_hi[2], q_lo[2]}, {2'b00, 64'hFFFF_FFFF_8000_0000});

      // Start with flush in the same idle cycle is dropped.
      start[1] = 1'b1; flush[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0; flush[1] = 1'b0;
      chk("start_flush_dropped_ready", 66'(ready[1]), 66'd1);
      watch_no_valid(1, 15, "start_flush_dropped_no_valid");

      for (int k = 0; k < 3; k++) begin
         nops = (k == 0) ? 20 : 150;
         for (int op = 0; op < 6; op++) begin
            for (int r = 0; r < nops; r++) begin
               r_add = (op == 1) || (op == 4) || (op == 5);
               r_lng = (op >= 2);
               r_sgn = r_lng ? ((op == 3) || (op == 5)) : 1'($urandom_range(0, 1));
               ra = rnd_op(); rb = rnd_op(); ralo = rnd_op(); rahi = $urandom;
               exp = ref_model(r_add, r_lng, r_sgn, ra, rb, ralo, rahi);
               run_op(k, r_add, r_lng, r_sgn, ra, rb, ralo, rahi, -1, got, lat, low_cnt);
               chk($sformatf("rnd k%0d op%0d a=%h b=%h", k, op, ra, rb), got, exp);
               chk($sformatf("rnd_latency k%0d op%0d", k, op), 66'(lat), 66'(n_steps(k) + 1));
            end
         end
      end

      // Asynchronous reset mid-MUL clears outputs immediately and discards the operation.
      dec = '0; a = 32'd7; b = 32'd6; start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_ready", 66'(ready[0]), 66'd1);
      chk("async_reset_q_lo", 66'(q_lo[0]), 66'd0);
      chk("async_reset_valid", 66'(valid[0]), 66'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      watch_no_valid(0, 40, "async_reset_discard");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
